cgra_operand_fetch: RTL and testbench

- Reader side of the register file's CGRA debug/operand port (`op_address` → `reg_o`).
- On a start command, walks a contiguous range of architectural registers through that port and streams each 32-bit value, tagged with its register index, to the CGRA over a valid/ready interface.
- Sits between the register file and the CGRA configuration/operand loader. Owns the `op_address` bus exclusively.

---
 rtl/cgra_fetch_pkg.sv | 20 ++
 rtl/cgra_operand_fetch_if.sv | 18 +
 rtl/cgra_fetch_fifo.sv | 60 ++++++
 rtl/cgra_operand_fetch.sv | 112 +++++++++++
 tb/tb_cgra_operand_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_fetch_pkg.sv
// Shared types for the CGRA operand fetch slice: FSM states and skid-buffer entry.
package cgra_fetch_pkg;

  localparam int unsigned CF_DATA_W = 32;
  localparam int unsigned CF_RA_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CF_DATA_W-1:0] data;
    logic [CF_RA_W-1:0]   idx;
    logic                 last;
  } entry_t;

endpackage

// File: rtl/cgra_operand_fetch_if.sv
// Valid/ready stream carrying register values and their indices to the CGRA loader.
interface cgra_operand_fetch_if
  import cgra_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = CF_DATA_W,
  parameter int unsigned RA_W   = CF_RA_W
) ();

  logic [DATA_W-1:0] data_o;
  logic [RA_W-1:0]   idx_o;
  logic              last_o;
  logic              valid_o;
  logic              ready_i;

  modport master (output data_o, idx_o, last_o, valid_o, input ready_i);
  modport slave  (input data_o, idx_o, last_o, valid_o, output ready_i);

endinterface

// File: rtl/cgra_fetch_fifo.sv
// Small synchronous skid buffer; push and pop may coincide even when full.
module cgra_fetch_fifo
  import cgra_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic   clk_i,
  input  logic   reset_n,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic [AW:0] fill
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign fill    = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only observable while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cgra_operand_fetch.sv
// Walks a contiguous register range through the register file op_address port
// and streams each value, tagged with its index, to the CGRA.
module cgra_operand_fetch
  import cgra_fetch_pkg::*;
#(
  parameter int unsigned DATA_W     = CF_DATA_W,
  parameter int unsigned OPA_W      = 10,
  parameter int unsigned RA_W       = CF_RA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [RA_W-1:0]   base_i,
  input  logic [RA_W:0]     count_i,
  output logic [OPA_W-1:0]  op_address_o,
  input  logic [DATA_W-1:0] reg_i,
  output logic              busy_o,
  output logic              done_o,
  cgra_operand_fetch_if.master out_if
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  state_t          state;
  logic [RA_W-1:0] cur;
  logic [RA_W:0]   rem;
  entry_t          push_e;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic [FAW:0]    fill;
  logic            drain_empty;

  assign pop   = !empty && out_if.ready_i;
  assign flush = abort_i && (state != S_IDLE);
  assign push  = (state == S_FETCH) && !abort_i && (!full || pop);
  // DONE must follow the edge that accepts the final word, so look ahead one pop.
  assign drain_empty = empty || ((fill == (FAW+1)'(1)) && pop);

  assign op_address_o = (state == S_FETCH) ? OPA_W'(cur) : '0;
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);

  assign out_if.valid_o = !empty;
  assign out_if.data_o  = empty ? '0 : head.data;
  assign out_if.idx_o   = empty ? '0 : head.idx;
  assign out_if.last_o  = !empty && head.last;

  // Build the entry sampled from the register file this cycle.
  always_comb begin
    push_e      = '0;
    push_e.data = reg_i;
    push_e.idx  = cur;
    push_e.last = (rem == (RA_W+1)'(1));
  end

  // Burst sequencing: abort dominates, start only honoured in IDLE.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cur   <= '0;
      rem   <= '0;
    end else if (abort_i) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              cur   <= base_i;
              rem   <= count_i;
              state <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (push) begin
            cur <= cur + RA_W'(1);
            rem <= rem - (RA_W+1)'(1);
            if (rem == (RA_W+1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_empty) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  cgra_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

endmodule

// File: tb/tb_cgra_operand_fetch.sv
// Self-checking bench for cgra_operand_fetch: queue-based reference of the
// expected word stream plus hand-computed literal expectations.
module tb_cgra_operand_fetch;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        abort_i;
  logic [4:0]  base_i;
  logic [5:0]  count_i;
  logic [9:0]  op_address_o;
  logic [31:0] reg_i;
  logic        busy_o;
  logic        done_o;

  cgra_operand_fetch_if #(.DATA_W(32), .RA_W(5)) out_if ();

  cgra_operand_fetch #(.DATA_W(32), .OPA_W(10), .RA_W(5), .FIFO_DEPTH(2)) dut (
    .clk_i        (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .base_i       (base_i),
    .count_i      (count_i),
    .op_address_o (op_address_o),
    .reg_i        (reg_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .out_if       (out_if)
  );

  // Register file model: combinational read, bench writes on negedge.
  logic [31:0] regs [32];
  assign reg_i = regs[op_address_o[4:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  typedef struct { int idx; bit last; } exp_t;
  exp_t exp_q [$];

  int          log_idx  [$];
  logic [31:0] log_data [$];
  bit          log_last [$];
  int          log_cyc  [$];

  int done_due  = -1;
  int done_seen = 0;
  int done_cyc  = -1;

  bit          stall_prev = 0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;
  logic        prev_last;

  int ready_mode = 0;
  int pat = 0;

  // Consumer ready generator.
  initial begin
    out_if.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_if.ready_i = 1'b1;
        1: begin out_if.ready_i = (pat == 0); pat = (pat + 1) % 3; end
        default: out_if.ready_i = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Compare process: checks every live cycle against the expected stream.
  always @(negedge clk) begin
    if (reset_n && !abort_i) begin
      chk("op_address_upper_zero", op_address_o[9:5], 0);
      if (!busy_o) chk("op_address_idle_zero", op_address_o, 0);
      if (stall_prev) begin
        chk("stall_valid_held", out_if.valid_o, 1);
        chk("stall_data_stable", out_if.data_o, prev_data);
        chk("stall_idx_stable", out_if.idx_o, prev_idx);
        chk("stall_last_stable", out_if.last_o, prev_last);
      end
      if (out_if.valid_o) begin
        chk("valid_has_expected_word", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("idx", out_if.idx_o, exp_q[0].idx);
          chk("data", out_if.data_o, regs[exp_q[0].idx]);
          chk("last", out_if.last_o, exp_q[0].last);
          if (out_if.ready_i) begin
            log_idx.push_back(int'(out_if.idx_o));
            log_data.push_back(out_if.data_o);
            log_last.push_back(out_if.last_o);
            log_cyc.push_back(cyc);
            if (exp_q[0].last) done_due = cyc + 1;
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = out_if.valid_o && !out_if.ready_i;
      prev_data  = out_if.data_o;
      prev_idx   = out_if.idx_o;
      prev_last  = out_if.last_o;
      chk("done_timing", done_o, (cyc == done_due));
      if (done_o) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    log_idx.delete();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic start_burst(input int b, input int c, input int mode, output int sc, output int d0);
    exp_t e;
    ready_mode = mode;
    @(posedge clk);
    #1;
    sc = cyc;
    d0 = done_seen;
    clear_log();
    for (int k = 0; k < c; k++) begin
      e.idx  = (b + k) % 32;
      e.last = (k == c - 1);
      exp_q.push_back(e);
    end
    if (c == 0) done_due = cyc + 1;
    base_i  = 5'(b);
    count_i = 6'(c);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic finish_burst(input int d0, input int c, input int budget);
    int n = 0;
    while (done_seen == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_count", done_seen, d0 + 1);
    chk("words_outstanding", exp_q.size(), 0);
    chk("word_count", log_idx.size(), c);
    @(negedge clk);
    chk("busy_low_after_done", busy_o, 0);
  endtask

  task automatic check_basic(input int sc);
    logic [31:0] lit [4];
    lit[0] = 32'h11; lit[1] = 32'h22; lit[2] = 32'h33; lit[3] = 32'h44;
    chk("basic_len", log_idx.size(), 4);
    if (log_idx.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("basic_idx", log_idx[k], 4 + k);
        chk("basic_data", log_data[k], lit[k]);
        chk("basic_last", log_last[k], (k == 3));
        chk("basic_cycle", log_cyc[k], sc + 2 + k);
      end
    end
    chk("basic_done_cycle", done_cyc, sc + 6);
  endtask

  int sc, d0, n;

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom();
    regs[4] = 32'h11; regs[5] = 32'h22; regs[6] = 32'h33; regs[7] = 32'h44;
    reset_n = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    base_i  = '0;
    count_i = '0;
    #2;
    chk("reset_valid", out_if.valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_op_address", op_address_o, 0);
    chk("reset_data_idx_last", {out_if.data_o, out_if.idx_o, out_if.last_o}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic burst
    start_burst(4, 4, 0, sc, d0);
    finish_burst(d0, 4, 100);
    check_basic(sc);

    // Wrap-around
    start_burst(30, 4, 0, sc, d0);
    finish_burst(d0, 4, 100);
    if (log_idx.size() == 4) begin
      chk("wrap_idx0", log_idx[0], 30);
      chk("wrap_idx1", log_idx[1], 31);
      chk("wrap_idx2", log_idx[2], 0);
      chk("wrap_idx3", log_idx[3], 1);
    end

    // Backpressure 1,0,0
    pat = 0;
    start_burst(12, 6, 1, sc, d0);
    finish_burst(d0, 6, 200);
    for (int k = 0; k < log_idx.size(); k++) chk("bp_idx", log_idx[k], 12 + k);

    // Zero count
    start_burst(9, 0, 0, sc, d0);
    finish_burst(d0, 0, 20);
    chk("zero_done_cycle", done_cyc, sc + 1);

    // Start ignored while busy
    start_burst(10, 3, 0, sc, d0);
    base_i  = 5'd20;
    count_i = 6'd5;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    finish_burst(d0, 3, 100);
    if (log_idx.size() == 3) begin
      chk("ign_idx0", log_idx[0], 10);
      chk("ign_idx2", log_idx[2], 12);
    end

    // Abort after two words
    start_burst(8, 10, 0, sc, d0);
    n = 0;
    while (log_idx.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("abort_words_reached", log_idx.size() >= 2, 1);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    exp_q.delete();
    stall_prev = 0;
    chk("abort_valid", out_if.valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    repeat (5) @(posedge clk);
    chk("abort_no_done", done_seen, d0);

    // Asynchronous reset mid-burst
    start_burst(0, 8, 1, sc, d0);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", out_if.valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_op_address", op_address_o, 0);
    chk("arst_data_idx_last", {out_if.data_o, out_if.idx_o, out_if.last_o}, 0);
    exp_q.delete();
    clear_log();
    done_due   = -1;
    stall_prev = 0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    chk("arst_no_done", done_seen, d0);
    start_burst(4, 4, 0, sc, d0);
    finish_burst(d0, 4, 100);
    check_basic(sc);

    // Write coherency: reg 5 written on the negedge before it is sampled
    regs[3] = 32'hA3; regs[4] = 32'hA4; regs[5] = 32'hA5; regs[6] = 32'hA6;
    start_burst(3, 4, 0, sc, d0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    regs[5] = 32'hDEAD;
    finish_burst(d0, 4, 100);
    if (log_idx.size() == 4) begin
      chk("coh_idx", log_idx[2], 5);
      chk("coh_data", log_data[2], 32'hDEAD);
      chk("coh_prev_data", log_data[1], 32'hA4);
    end

    // Randomized bursts
    for (int t = 0; t < 25; t++) begin
      int b, c, m;
      b = $urandom_range(0, 31);
      c = $urandom_range(0, 32);
      m = $urandom_range(0, 2);
      @(negedge clk);
      regs[$urandom_range(0, 31)] = $urandom();
      start_burst(b, c, m, sc, d0);
      finish_burst(d0, c, 400);
      for (int k = 0; k < log_idx.size(); k++) chk("rand_idx", log_idx[k], (b + k) % 32);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
